rf_wb_arbiter: RTL

- Arbitrates the single register-file write port among several writeback sources (ALU pipeline, LSU load return, multi-cycle MUL/DIV unit).
- Round-robin, one grant per cycle, valid/ready per source, registered write stage toward the register file.
- Sits between the EX/MEM/MDU result buses and the RF write port.
- Its write-stage outputs drive RF write and the pending-clear path of the hazard scoreboard.

---
 rtl/rf_wb_arbiter_if.sv | 28 ++
 rtl/rf_wb_arbiter.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter_if.sv
// Writeback arbiter bus: per-source result requests plus the registered
// register-file write stage and conflict statistics.
interface rf_wb_arbiter_if #(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = 32
);
   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0]      req_ready;
   logic [5*NUM_REQ-1:0]    req_rd;
   logic [XLEN*NUM_REQ-1:0] req_data;
   logic                    rf_wen;
   logic [4:0]              rf_waddr;
   logic [XLEN-1:0]         rf_wdata;
   logic [NUM_REQ-1:0]      wb_src;
   logic [31:0]             conflict_cnt;

   // Arbiter side: consumes requests, produces grants and the write stage.
   modport slave (
      input  req_valid, req_rd, req_data,
      output req_ready, rf_wen, rf_waddr, rf_wdata, wb_src, conflict_cnt
   );

   // Source/observer side: presents requests, sees grants and the write stage.
   modport master (
      output req_valid, req_rd, req_data,
      input  req_ready, rf_wen, rf_waddr, rf_wdata, wb_src, conflict_cnt
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port. One source is
// granted per cycle; the granted result is registered into a one-cycle write
// stage that drives the RF and the scoreboard pending-clear path.
module rf_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = 32
) (
   input  logic             clk,
   input  logic             rst,
   rf_wb_arbiter_if.slave   bus
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

   // Rotate requests so ptr sits at bit 0, isolate the lowest set bit, then
   // rotate back: this yields the first valid index at or after ptr.
   function automatic logic [NUM_REQ-1:0] rr_pick(
      input logic [NUM_REQ-1:0] valid,
      input logic [PTR_W-1:0]   ptr
   );
      logic [2*NUM_REQ-1:0] dbl;
      logic [NUM_REQ-1:0]   rot;
      logic [NUM_REQ-1:0]   low;
      logic [2*NUM_REQ-1:0] back;
      dbl  = {valid, valid} >> ptr;
      rot  = dbl[NUM_REQ-1:0];
      low  = rot & (~rot + NUM_REQ'(1));
      back = {low, low} << ptr;
      return back[2*NUM_REQ-1:NUM_REQ];
   endfunction

   // Index of the set bit of a one-hot vector (0 when empty).
   function automatic logic [PTR_W-1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
      logic [PTR_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = idx | (oh[i] ? PTR_W'(i) : {PTR_W{1'b0}});
      end
      return idx;
   endfunction

   // Number of asserted request lines.
   function automatic logic [3:0] popcnt(input logic [NUM_REQ-1:0] v);
      logic [3:0] cnt;
      cnt = 4'd0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cnt = cnt + {3'b000, v[i]};
      end
      return cnt;
   endfunction

   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic               wen_q, wen_d;
   logic [4:0]         waddr_q, waddr_d;
   logic [XLEN-1:0]    wdata_q, wdata_d;
   logic [NUM_REQ-1:0] src_q, src_d;
   logic [31:0]        cnt_q, cnt_d;

   logic [NUM_REQ-1:0] grant_s;
   logic [PTR_W-1:0]   grant_idx_s;
   logic               xfer_s;
   logic [4:0]         sel_rd_s;
   logic [XLEN-1:0]    sel_data_s;

   // Grant selection; nothing is accepted while reset is held.
   always_comb begin
      grant_s = '0;
      if (rst) begin
         grant_s = '0;
      end else begin
         grant_s = rr_pick(bus.req_valid, ptr_q);
      end
   end

   assign grant_idx_s   = onehot_idx(grant_s);
   assign xfer_s        = |grant_s;
   assign bus.req_ready = grant_s;

   // AND-OR mux of the granted source's destination and result.
   always_comb begin
      sel_rd_s   = 5'd0;
      sel_data_s = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_rd_s   = sel_rd_s   | (bus.req_rd[5*i +: 5]       & {5{grant_s[i]}});
         sel_data_s = sel_data_s | (bus.req_data[XLEN*i +: XLEN] & {XLEN{grant_s[i]}});
      end
   end

   // Next-state: pointer moves past the winner, write stage captures the
   // winner, conflict counter saturates.
   always_comb begin
      ptr_d   = ptr_q;
      wen_d   = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      src_d   = grant_s;
      cnt_d   = cnt_q;
      if (xfer_s) begin
         ptr_d   = (grant_idx_s == LAST_IDX) ? {PTR_W{1'b0}} : grant_idx_s + PTR_W'(1);
         wen_d   = (sel_rd_s != 5'd0);
         waddr_d = sel_rd_s;
         wdata_d = sel_data_s;
      end else begin
         ptr_d   = ptr_q;
         wen_d   = 1'b0;
         waddr_d = waddr_q;
         wdata_d = wdata_q;
      end
      if ((popcnt(bus.req_valid) >= 4'd2) && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_d = cnt_q + 32'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers; reset drops any pending write-stage entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q   <= '0;
         wen_q   <= 1'b0;
         waddr_q <= 5'd0;
         wdata_q <= '0;
         src_q   <= '0;
         cnt_q   <= 32'd0;
      end else begin
         ptr_q   <= ptr_d;
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         src_q   <= src_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.rf_wen       = wen_q;
   assign bus.rf_waddr     = waddr_q;
   assign bus.rf_wdata     = wdata_q;
   assign bus.wb_src       = src_q;
   assign bus.conflict_cnt = cnt_q;

endmodule
